// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 32-bit select path.
// Grants are held until the resource signals done, with bounded relocking and a hang timeout.
module mux4_rr_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_LOCK       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_i,
  input  logic [3:0] lock_i,
  input  logic       done_i,
  output logic [3:0] gnt_o,
  output logic [1:0] sel_o,
  output logic       busy_o,
  output logic       timeout_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  localparam int HW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(MAX_LOCK - 1);
  localparam bit            TMO_EN    = (TIMEOUT_CYCLES != 0);

  logic [0:0]    state_r, state_s;
  logic [1:0]    sel_r, sel_s;
  logic [1:0]    ptr_r, ptr_s;
  logic [3:0]    gnt_r, gnt_s;
  logic [HW-1:0] hold_r, hold_s;
  logic [LW-1:0] lock_r, lock_s;
  logic          timeout_r, timeout_s;
  logic [2:0]    pick_s;
  logic [2:0]    repick_s;
  logic          relock_s;
  logic          tmo_hit_s;

  // Returns {found, index} of the first set request scanning start, start+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Arbitration candidates: fresh pick from IDLE and release pick with the owner masked.
  always_comb begin
    pick_s    = rr_pick(req_i, ptr_r);
    repick_s  = rr_pick(req_i & ~(4'b0001 << sel_r), sel_r + 2'd1);
    relock_s  = lock_i[sel_r] && req_i[sel_r] && (lock_r < LOCK_LAST);
    tmo_hit_s = TMO_EN && (hold_r == HOLD_LAST);
  end

  // Next-state logic for ownership, pointer and counters.
  always_comb begin
    state_s   = state_r;
    sel_s     = sel_r;
    ptr_s     = ptr_r;
    gnt_s     = gnt_r;
    hold_s    = hold_r;
    lock_s    = lock_r;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_s[2]) begin
          state_s = OWN;
          sel_s   = pick_s[1:0];
          gnt_s   = 4'b0001 << pick_s[1:0];
          hold_s  = '0;
          lock_s  = '0;
        end else begin
          gnt_s = 4'b0000;
        end
      end
      OWN: begin
        if (done_i && relock_s) begin
          lock_s = lock_r + LW'(1);
          hold_s = '0;
        end else if (done_i || tmo_hit_s) begin
          // done_i has priority, so a coincident timeout is a normal release
          timeout_s = !done_i;
          ptr_s     = sel_r + 2'd1;
          lock_s    = '0;
          hold_s    = '0;
          if (repick_s[2]) begin
            sel_s = repick_s[1:0];
            gnt_s = 4'b0001 << repick_s[1:0];
          end else begin
            state_s = IDLE;
            gnt_s   = 4'b0000;
          end
        end else if (hold_r != {HW{1'b1}}) begin
          hold_s = hold_r + HW'(1);
        end else begin
          hold_s = hold_r;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = 4'b0000;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      sel_r     <= 2'd0;
      ptr_r     <= 2'd0;
      gnt_r     <= 4'b0000;
      hold_r    <= '0;
      lock_r    <= '0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      sel_r     <= sel_s;
      ptr_r     <= ptr_s;
      gnt_r     <= gnt_s;
      hold_r    <= hold_s;
      lock_r    <= lock_s;
      timeout_r <= timeout_s;
    end
  end

  assign gnt_o     = gnt_r;
  assign sel_o     = sel_r;
  assign busy_o    = (state_r == OWN);
  assign timeout_o = timeout_r;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus random traffic, checked by a
// queue-based scoreboard fed from an abstract ownership model.
module tb_mux4_rr_arbiter;

  localparam int TO = 16;
  localparam int ML = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_i;
  logic [3:0] lock_i;
  logic       done_i;
  logic [3:0] gnt_o;
  logic [1:0] sel_o;
  logic       busy_o;
  logic       timeout_o;

  int total;
  int bad;
  logic [7:0] expq[$];

  // model: owner -1 means nobody owns the resource
  int m_owner, m_sel, m_ptr, m_held, m_locks;
  bit m_tmo;

  mux4_rr_arbiter #(.TIMEOUT_CYCLES(TO), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .lock_i(lock_i), .done_i(done_i),
    .gnt_o(gnt_o), .sel_o(sel_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_release();
    int w;
    m_ptr   = (m_owner + 1) % 4;
    m_locks = 0;
    w = pick(req_i & ~(4'b0001 << m_owner), m_ptr);
    if (w >= 0) begin
      m_owner = w;
      m_sel   = w;
      m_held  = 0;
    end else begin
      m_owner = -1;
    end
  endtask

  task automatic model_step();
    int w;
    logic [3:0] g;
    if (!rst_n) begin
      m_owner = -1; m_sel = 0; m_ptr = 0; m_held = 0; m_locks = 0; m_tmo = 1'b0;
    end else begin
      m_tmo = 1'b0;
      if (m_owner < 0) begin
        w = pick(req_i, m_ptr);
        if (w >= 0) begin
          m_owner = w; m_sel = w; m_held = 0; m_locks = 0;
        end
      end else if (done_i) begin
        if (lock_i[m_owner] && req_i[m_owner] && m_locks < ML - 1) begin
          m_locks++;
          m_held = 0;
        end else begin
          model_release();
        end
      end else if (TO != 0 && m_held == TO - 1) begin
        model_release();
        m_tmo = 1'b1;
      end else begin
        m_held++;
      end
    end
    g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    expq.push_back({g, 2'(m_sel), (m_owner >= 0), m_tmo});
  endtask

  // Reference model: predicts outputs for every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: compares DUT outputs just after each edge against the scoreboard.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = expq.pop_front();
        chk("sb_outputs", {24'd0, gnt_o, sel_o, busy_o, timeout_o}, {24'd0, e});
      end
    end
  end

  // Drive inputs at the falling edge, then wait for the next falling edge.
  task automatic step(input logic [3:0] r, input logic [3:0] l, input logic d);
    req_i  = r;
    lock_i = l;
    done_i = d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req_i = 4'b0000; lock_i = 4'b0000; done_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", {28'd0, gnt_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_sel", {30'd0, sel_o}, 32'd0);
    rst_n = 1'b1;

    // single grant and release to idle with sel held
    step(4'b0100, 4'b0000, 1'b0);
    chk("t1_gnt", {28'd0, gnt_o}, 32'h4);
    chk("t1_sel", {30'd0, sel_o}, 32'd2);
    chk("t1_busy", {31'd0, busy_o}, 32'd1);
    step(4'b0100, 4'b0000, 1'b1);
    chk("t1_rel_gnt", {28'd0, gnt_o}, 32'd0);
    chk("t1_rel_busy", {31'd0, busy_o}, 32'd0);
    chk("t1_rel_sel", {30'd0, sel_o}, 32'd2);

    // full rotation with no idle gap
    do_reset();
    step(4'b1111, 4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("t2_rot", {28'd0, gnt_o}, 32'(4'b0001 << (k % 4)));
      step(4'b1111, 4'b0000, 1'b0);
      step(4'b1111, 4'b0000, 1'b1);
    end
    step(4'b0000, 4'b0000, 1'b1);

    // bounded locked ownership
    step(4'b0011, 4'b0001, 1'b0);
    chk("t3_first", {28'd0, gnt_o}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      step(4'b0011, 4'b0001, 1'b1);
      chk("t3_lock", {28'd0, gnt_o}, (k < 3) ? 32'h1 : 32'h2);
    end
    step(4'b0000, 4'b0000, 1'b1);

    // hang timeout hands over to requester 2
    step(4'b0010, 4'b0000, 1'b0);
    chk("t4_owner", {28'd0, gnt_o}, 32'h2);
    for (int k = 0; k < TO - 1; k++) step(4'b0110, 4'b0000, 1'b0);
    chk("t4_pre_tmo", {31'd0, timeout_o}, 32'd0);
    chk("t4_pre_gnt", {28'd0, gnt_o}, 32'h2);
    step(4'b0110, 4'b0000, 1'b0);
    chk("t4_tmo", {31'd0, timeout_o}, 32'd1);
    chk("t4_new_gnt", {28'd0, gnt_o}, 32'h4);
    step(4'b0000, 4'b0000, 1'b1);
    chk("t4_tmo_pulse", {31'd0, timeout_o}, 32'd0);

    // done coincident with the timeout cycle
    step(4'b0001, 4'b0000, 1'b0);
    for (int k = 0; k < TO - 1; k++) step(4'b0001, 4'b0000, 1'b0);
    step(4'b0001, 4'b0000, 1'b1);
    chk("t5_no_tmo", {31'd0, timeout_o}, 32'd0);
    chk("t5_gnt", {28'd0, gnt_o}, 32'd0);
    chk("t5_busy", {31'd0, busy_o}, 32'd0);

    // asynchronous reset between edges
    step(4'b0010, 4'b0000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_gnt", {28'd0, gnt_o}, 32'd0);
    chk("t6_busy", {31'd0, busy_o}, 32'd0);
    chk("t6_sel", {30'd0, sel_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1000, 4'b0000, 1'b0);
    chk("t6_regrant", {28'd0, gnt_o}, 32'h8);
    chk("t6_sel3", {30'd0, sel_o}, 32'd3);
    step(4'b1001, 4'b0000, 1'b1);
    chk("t6_wrap", {28'd0, gnt_o}, 32'h1);

    // random traffic, alternating chatty and quiet done phases
    for (int n = 0; n < 800; n++) begin
      logic [3:0] r;
      logic [3:0] l;
      logic       d;
      r = 4'($urandom_range(0, 15));
      l = 4'($urandom_range(0, 15));
      if ((n / 100) % 2 == 0) d = ($urandom_range(0, 2) == 0);
      else d = ($urandom_range(0, 24) == 0);
      if (n == 450) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      step(r, l, d);
    end

    step(4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
